// File: rtl/data_mem_arbiter.sv
// ----------------------------------------------------------------------------
// data_mem_arbiter
//
// Two-requester round-robin arbiter in front of a single-port data memory.
// One access is handled at a time in three steps:
//   IDLE   : pick a winner, pulse its gnt (combinational), latch its command
//   ACCESS : drive one read or write strobe to the memory (valid accesses only)
//   DONE   : pulse the owner's done, with err set for an invalid address
// This gives one access every three cycles at most.
//
// Ports
//   clk, reset                 : clock, asynchronous active-high reset
//   rN_req/we/addr/wdata       : requester N command, held until rN_gnt
//   rN_gnt                     : one-cycle accept pulse (combinational in IDLE)
//   rN_done/rN_err             : one-cycle completion pulse / error flag
//   rN_rdata                   : last read result for requester N
//   mem_read/mem_write         : memory strobes, high only during ACCESS
//   mem_address/mem_write_data : memory command, zero outside ACCESS
//   mem_read_data              : combinational read data from the memory
// ----------------------------------------------------------------------------
module data_mem_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 128
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              r0_req,
  input  logic              r0_we,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  output logic              r0_gnt,
  output logic              r0_done,
  output logic              r0_err,
  output logic [DATA_W-1:0] r0_rdata,
  input  logic              r1_req,
  input  logic              r1_we,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r1_gnt,
  output logic              r1_done,
  output logic              r1_err,
  output logic [DATA_W-1:0] r1_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  input  logic [DATA_W-1:0] mem_read_data
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  // One past the last valid byte address; one extra bit so the compare
  // cannot wrap when 4*DEPTH reaches 2**ADDR_W.
  localparam logic [ADDR_W:0] ADDR_LIMIT = (ADDR_W+1)'(DEPTH * 32'd4);

  // Word-aligned and inside the memory.
  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    return (a[1:0] == 2'b00) && ({1'b0, a} < ADDR_LIMIT);
  endfunction

  state_t            state_r;
  logic              last_r;      // requester served most recently
  logic              owner_r;     // requester owning the current access
  logic              valid_r;     // current access has a legal address
  logic              mem_read_r;
  logic              mem_write_r;
  logic [ADDR_W-1:0] mem_address_r;
  logic [DATA_W-1:0] mem_write_data_r;
  logic              r0_done_r;
  logic              r1_done_r;
  logic              r0_err_r;
  logic              r1_err_r;
  logic [DATA_W-1:0] r0_rdata_r;
  logic [DATA_W-1:0] r1_rdata_r;

  logic              gnt_any_s;
  logic              win_s;
  logic              win_we_s;
  logic              win_valid_s;
  logic [ADDR_W-1:0] win_addr_s;
  logic [DATA_W-1:0] win_wdata_s;

  // Round-robin winner selection and command mux for the IDLE grant.
  always_comb begin
    gnt_any_s   = 1'b0;
    win_s       = 1'b0;
    win_we_s    = 1'b0;
    win_addr_s  = '0;
    win_wdata_s = '0;
    win_valid_s = 1'b0;
    // reset is folded in so gnt is forced low while reset is held
    gnt_any_s = (state_r == IDLE) && !reset && (r0_req || r1_req);
    if (r0_req && r1_req) begin
      win_s = ~last_r;
    end else if (r1_req) begin
      win_s = 1'b1;
    end else begin
      win_s = 1'b0;
    end
    if (win_s) begin
      win_we_s    = r1_we;
      win_addr_s  = r1_addr;
      win_wdata_s = r1_wdata;
    end else begin
      win_we_s    = r0_we;
      win_addr_s  = r0_addr;
      win_wdata_s = r0_wdata;
    end
    win_valid_s = addr_ok(win_addr_s);
  end

  // Access sequencer: state, arbitration pointer and all registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r          <= IDLE;
      last_r           <= 1'b1;
      owner_r          <= 1'b0;
      valid_r          <= 1'b0;
      mem_read_r       <= 1'b0;
      mem_write_r      <= 1'b0;
      mem_address_r    <= '0;
      mem_write_data_r <= '0;
      r0_done_r        <= 1'b0;
      r1_done_r        <= 1'b0;
      r0_err_r         <= 1'b0;
      r1_err_r         <= 1'b0;
      r0_rdata_r       <= '0;
      r1_rdata_r       <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (gnt_any_s) begin
            state_r          <= ACCESS;
            last_r           <= win_s;
            owner_r          <= win_s;
            valid_r          <= win_valid_s;
            mem_address_r    <= win_addr_s;
            mem_write_data_r <= win_wdata_s;
            // invalid addresses never reach the memory
            mem_write_r      <= win_valid_s && win_we_s;
            mem_read_r       <= win_valid_s && !win_we_s;
          end else begin
            state_r <= IDLE;
          end
        end
        ACCESS: begin
          state_r          <= DONE;
          mem_read_r       <= 1'b0;
          mem_write_r      <= 1'b0;
          mem_address_r    <= '0;
          mem_write_data_r <= '0;
          // read data is captured while the address is still on the bus
          if (!valid_r) begin
            if (owner_r) begin
              r1_rdata_r <= '0;
            end else begin
              r0_rdata_r <= '0;
            end
          end else if (mem_read_r) begin
            if (owner_r) begin
              r1_rdata_r <= mem_read_data;
            end else begin
              r0_rdata_r <= mem_read_data;
            end
          end else begin
            r0_rdata_r <= r0_rdata_r;
          end
          r0_done_r <= !owner_r;
          r1_done_r <= owner_r;
          r0_err_r  <= !owner_r && !valid_r;
          r1_err_r  <= owner_r && !valid_r;
        end
        DONE: begin
          state_r   <= IDLE;
          r0_done_r <= 1'b0;
          r1_done_r <= 1'b0;
          r0_err_r  <= 1'b0;
          r1_err_r  <= 1'b0;
        end
        default: begin
          state_r          <= IDLE;
          mem_read_r       <= 1'b0;
          mem_write_r      <= 1'b0;
          mem_address_r    <= '0;
          mem_write_data_r <= '0;
          r0_done_r        <= 1'b0;
          r1_done_r        <= 1'b0;
          r0_err_r         <= 1'b0;
          r1_err_r         <= 1'b0;
        end
      endcase
    end
  end

  assign r0_gnt         = gnt_any_s && !win_s;
  assign r1_gnt         = gnt_any_s && win_s;
  assign r0_done        = r0_done_r;
  assign r1_done        = r1_done_r;
  assign r0_err         = r0_err_r;
  assign r1_err         = r1_err_r;
  assign r0_rdata       = r0_rdata_r;
  assign r1_rdata       = r1_rdata_r;
  assign mem_read       = mem_read_r;
  assign mem_write      = mem_write_r;
  assign mem_address    = mem_address_r;
  assign mem_write_data = mem_write_data_r;

endmodule
